nibble_serial_addsub_ctrl: RTL and testbench

//  Sequencer that runs a WIDE add/subtract on the 4-bit ripple add/sub datapath, one nibble per clock,

---
 rtl/nibble_addsub_pkg.sv | 14 +
 rtl/nibble_serial_addsub_ctrl_if.sv | 32 +++
 rtl/nibble_addsub.sv | 30 +++
 rtl/nibble_serial_addsub_ctrl.sv | 136 +++++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_addsub_pkg.sv
// Shared constants and state encoding for the nibble-serial add/sub sequencer.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the slice, the bus interface and the controller.
package nibble_addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Requester <-> sequencer bundle: start/operands in, busy/done/result out.
// Latency: wires only.
// Backpressure: requester may present start only while busy is low.
interface nibble_serial_addsub_ctrl_if
    import nibble_addsub_pkg::*;
#(
    parameter int NIBBLES = 4
);

    localparam int W = NIBBLE_W * NIBBLES;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow
    );

endinterface

// File: rtl/nibble_addsub.sv
// 4-bit ripple adder slice with carry-in; exposes carry into bit 3 for overflow.
// Latency: combinational.
// Backpressure: none.
module nibble_addsub
    import nibble_addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W:0] c;

    always_comb begin
        c      = '0;
        sum    = '0;
        c[0]   = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout = c[NIBBLE_W];
    assign c3   = c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Wide add/sub run one nibble per clock through a single slice, LSB nibble first.
// Latency: done pulses NIBBLES+1 cycles after the accept cycle.
// Backpressure: start is ignored while busy; accepted in IDLE or in the DONE cycle.
module nibble_serial_addsub_ctrl
    import nibble_addsub_pkg::*;
#(
    parameter int NIBBLES = 4
)(
    input  logic                          clk,
    input  logic                          rst_n,
    nibble_serial_addsub_ctrl_if.slave    bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_e             state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic               carry_q,  carry_d;
    logic               sub_q,    sub_d;
    logic [W-1:0]       a_q,      a_d;
    logic [W-1:0]       b_q,      b_d;
    logic [W-1:0]       shadow_q, shadow_d;
    logic [W-1:0]       result_q, result_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic                nib_c3;

    // Subtract is A + ~B + 1: B is inverted here, the +1 is the initial carry.
    assign nib_a = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
    assign nib_b = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};

    nibble_addsub u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout),
        .c3   (nib_c3)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        a_d      = a_q;
        b_d      = b_q;
        shadow_d = shadow_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.sub;
                    carry_d = bus.sub;
                    idx_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                shadow_d[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = nib_sum;
                carry_d = nib_cout;
                if (idx_q == IDX_LAST) begin
                    // Outputs move only here, so the requester never sees a partial sum.
                    result_d = shadow_d;
                    cout_d   = nib_cout;
                    ovf_d    = nib_c3 ^ nib_cout;
                    idx_d    = '0;
                    state_d  = DONE;
                    done_d   = 1'b1;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed bench for the nibble-serial add/sub sequencer at NIBBLES=4.
module tb_nibble_serial_addsub_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    nibble_serial_addsub_ctrl_if #(.NIBBLES(4)) bus ();

    nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One op from IDLE; lat counts negedges from the accept cycle to the first done sample.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         output logic [15:0] res, output logic co, output logic ov,
                         output int lat, output logic busy_ok);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        lat       = 0;
        busy_ok   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.done) break;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        res = bus.result;
        co  = bus.cout;
        ov  = bus.overflow;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.cout, bus.overflow} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {bus.busy, bus.done, bus.cout, bus.overflow});
        end
        checks++;
        if (bus.result !== 16'h0000) begin
            failures++;
            $display("FAIL reset_result got=%h exp=0000", bus.result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [15:0] r; logic c, o, bok; int lat;
        do_op(16'h1234, 16'h0FCD, 1'b0, r, c, o, lat, bok);
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL add_latency got=%0d exp=5", lat); end
        checks++;
        if (r !== 16'h2201) begin failures++; $display("FAIL add_result got=%h exp=2201", r); end
        checks++;
        if ({c, o} !== 2'b00) begin failures++; $display("FAIL add_cout_ovf got=%b exp=00", {c, o}); end
        checks++;
        if (bok !== 1'b1) begin failures++; $display("FAIL add_busy got=%b exp=1", bok); end
        @(negedge clk);
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL add_done_pulse got=%b exp=00", {bus.done, bus.busy});
        end
    endtask

    task automatic test_sub_borrow();
        logic [15:0] r; logic c, o, bok; int lat;
        do_op(16'h0001, 16'h0002, 1'b1, r, c, o, lat, bok);
        checks++;
        if (r !== 16'hFFFF) begin failures++; $display("FAIL sub_result got=%h exp=ffff", r); end
        checks++;
        if ({c, o} !== 2'b00) begin failures++; $display("FAIL sub_cout_ovf got=%b exp=00", {c, o}); end
    endtask

    task automatic test_overflow();
        logic [15:0] r; logic c, o, bok; int lat;
        do_op(16'h8000, 16'h0001, 1'b1, r, c, o, lat, bok);
        checks++;
        if (r !== 16'h7FFF) begin failures++; $display("FAIL ovf_sub_result got=%h exp=7fff", r); end
        checks++;
        if ({c, o} !== 2'b11) begin failures++; $display("FAIL ovf_sub_flags got=%b exp=11", {c, o}); end
        do_op(16'h7FFF, 16'h0001, 1'b0, r, c, o, lat, bok);
        checks++;
        if (r !== 16'h8000) begin failures++; $display("FAIL ovf_add_result got=%h exp=8000", r); end
        checks++;
        if ({c, o} !== 2'b01) begin failures++; $display("FAIL ovf_add_flags got=%b exp=01", {c, o}); end
    endtask

    task automatic test_wrap();
        logic [15:0] r; logic c, o, bok; int lat;
        do_op(16'hFFFF, 16'h0001, 1'b0, r, c, o, lat, bok);
        checks++;
        if (r !== 16'h0000) begin failures++; $display("FAIL wrap_result got=%h exp=0000", r); end
        checks++;
        if ({c, o} !== 2'b10) begin failures++; $display("FAIL wrap_flags got=%b exp=10", {c, o}); end
    endtask

    // start held high through RUN with changing operands; second op taken in the DONE cycle.
    task automatic test_back_to_back();
        logic [10:1] busy_v, done_v;
        logic [15:0] held1, held2, r1, r2;
        logic        c1, o1, c2, o2;
        busy_v = '0; done_v = '0;
        held1 = '0; held2 = '0; r1 = '0; r2 = '0;
        c1 = 1'b0; o1 = 1'b0; c2 = 1'b0; o2 = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.sub   = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            busy_v[n] = bus.busy;
            done_v[n] = bus.done;
            if (n == 1) begin
                bus.a   = 16'h0F0F;
                bus.b   = 16'h0101;
                bus.sub = 1'b1;
            end
            if (n == 2) held1 = bus.result;
            if (n == 5) begin r1 = bus.result; c1 = bus.cout; o1 = bus.overflow; end
            if (n == 6) bus.start = 1'b0;
            if (n == 7) held2 = bus.result;
            if (n == 10) begin r2 = bus.result; c2 = bus.cout; o2 = bus.overflow; end
        end
        checks++;
        if (busy_v !== 10'b0111101111) begin
            failures++; $display("FAIL b2b_busy got=%b exp=0111101111", busy_v);
        end
        checks++;
        if (done_v !== 10'b1000010000) begin
            failures++; $display("FAIL b2b_done got=%b exp=1000010000", done_v);
        end
        checks++;
        if (held1 !== 16'h0000) begin failures++; $display("FAIL b2b_held_prev got=%h exp=0000", held1); end
        checks++;
        if ({r1, c1, o1} !== {16'h3333, 2'b00}) begin
            failures++; $display("FAIL b2b_first got=%h/%b%b exp=3333/00", r1, c1, o1);
        end
        checks++;
        if (held2 !== 16'h3333) begin failures++; $display("FAIL b2b_held_first got=%h exp=3333", held2); end
        checks++;
        if ({r2, c2, o2} !== {16'h0E0E, 2'b10}) begin
            failures++; $display("FAIL b2b_second got=%h/%b%b exp=0e0e/10", r2, c2, o2);
        end
        @(negedge clk);
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            failures++; $display("FAIL b2b_idle got=%b exp=00", {bus.done, bus.busy});
        end
    endtask

    task automatic test_reset_mid_run();
        logic        saw_done;
        logic [15:0] r; logic c, o, bok; int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h0FCD;
        bus.sub   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.cout, bus.overflow, bus.result} !== 20'h0) begin
            failures++;
            $display("FAIL midrst_outputs got=%b%b%b%b/%h exp=0000/0000",
                     bus.busy, bus.done, bus.cout, bus.overflow, bus.result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin failures++; $display("FAIL midrst_no_done got=%b exp=0", saw_done); end
        do_op(16'h00FF, 16'h0001, 1'b0, r, c, o, lat, bok);
        checks++;
        if ({r, c, o} !== {16'h0100, 2'b00} || lat !== 5) begin
            failures++; $display("FAIL midrst_after got=%h/%b%b lat=%0d exp=0100/00 lat=5", r, c, o, lat);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_sub_borrow();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
